// File: rtl/ir_fetch_if.sv
// Bundle between the fetch unit and its surroundings: control handshake, memory port and decoded IR.
// master = control FSM / instruction memory side, slave = the fetch unit itself.
interface ir_fetch_if #(
   parameter int word_size = 32,
   parameter int imm_size  = 16
);
   logic                 fetch_start;
   logic                 flush;
   logic [word_size-1:0] pc;
   logic                 mem_req;
   logic [word_size-1:0] mem_addr;
   logic [word_size-1:0] mem_rdata;
   logic                 mem_ack;
   logic                 busy;
   logic                 ir_valid;
   logic                 fetch_err;
   logic [word_size-1:0] ir;
   logic [5:0]           opcode;
   logic [4:0]           rs;
   logic [4:0]           rt;
   logic [4:0]           rd;
   logic [4:0]           shamt;
   logic [5:0]           funct;
   logic [imm_size-1:0]  imm;
   logic [25:0]          target;

   modport master (
      output fetch_start, flush, pc, mem_rdata, mem_ack,
      input  mem_req, mem_addr, busy, ir_valid, fetch_err, ir,
             opcode, rs, rt, rd, shamt, funct, imm, target
   );

   modport slave (
      input  fetch_start, flush, pc, mem_rdata, mem_ack,
      output mem_req, mem_addr, busy, ir_valid, fetch_err, ir,
             opcode, rs, rt, rd, shamt, funct, imm, target
   );
endinterface

// File: rtl/ir_fetch_unit.sv
// Instruction fetch + instruction register: one memory read per fetch_start, IR latch,
// field decode, and a bounded wait that reports a memory that never acknowledges.
module ir_fetch_unit #(
   parameter int word_size      = 32,
   parameter int imm_size       = 16,
   parameter int timeout_cycles = 16
) (
   input  logic         clk,
   input  logic         reset,
   ir_fetch_if.slave    bus
);

   typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_e;

   state_e               state_q, state_d;
   logic [word_size-1:0] addr_q, addr_d;
   logic [word_size-1:0] ir_q, ir_d;
   logic [7:0]           cnt_q, cnt_d;

   localparam logic [7:0] LastWait = 8'(timeout_cycles - 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         ir_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
      end
   end

   // flush outranks a same-cycle ack, and an ack on the final wait cycle still wins over timeout
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      ir_d    = ir_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.fetch_start) begin
               addr_d  = bus.pc;
               cnt_d   = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            if (bus.flush) begin
               state_d = IDLE;
            end else if (bus.mem_ack) begin
               ir_d    = bus.mem_rdata;
               state_d = DONE;
            end else if (cnt_q == LastWait) begin
               state_d = ERR;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_req   = (state_q == REQ);
      bus.busy      = (state_q != IDLE);
      bus.ir_valid  = (state_q == DONE);
      bus.fetch_err = (state_q == ERR);
      bus.mem_addr  = addr_q;
      bus.ir        = ir_q;
      bus.opcode    = ir_q[31:26];
      bus.rs        = ir_q[25:21];
      bus.rt        = ir_q[20:16];
      bus.rd        = ir_q[15:11];
      bus.shamt     = ir_q[10:6];
      bus.funct     = ir_q[5:0];
      bus.imm       = ir_q[imm_size-1:0];
      bus.target    = ir_q[25:0];
   end

endmodule

// File: doc/ir_fetch_unit.md
# ir_fetch_unit

Instruction fetch and instruction-register stage of the multi-cycle CPU. On request from the control FSM it issues one read to instruction memory, waits for the memory acknowledge, and latches the returned word into the instruction register (IR). It decodes the IR into its fields. `imm` feeds the zero- and sign-extend units directly and `target` feeds jump-address formation. A bounded wait timer reports a memory that never answers.

## Interface
- `word_size`, 32, data/address width
- `imm_size`, 16, immediate field width (IR bits [imm_size-1:0])
- `timeout_cycles`, 16, max REQ cycles without ack before error; legal range 1..255

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `fetch_start`  in  1  begin a fetch at `pc`; accepted only in IDLE
- `flush`  in  1  abort an outstanding fetch
- `pc`  in  word_size  fetch address, sampled on the accepting edge
- `mem_req`  out  1  read request to instruction memory
- `mem_addr`  out  word_size  latched fetch address
- `mem_rdata`  in  word_size  instruction word; valid when `mem_ack`=1
- `mem_ack`  in  1  read data valid this cycle
- `busy`  out  1  state != IDLE
- `ir_valid`  out  1  one-cycle pulse: IR just updated
- `fetch_err`  out  1  one-cycle pulse: timeout, IR not updated
- `ir`  out  word_size  instruction register
- `opcode` out 6 ir[31:26]; `rs` out 5 ir[25:21]; `rt` out 5 ir[20:16]; `rd` out 5 ir[15:11]; `shamt` out 5 ir[10:6]; `funct` out 6 ir[5:0]
- `imm`  out  imm_size  ir[imm_size-1:0]
- `target`  out  26  ir[25:0]

## Operation
- States: IDLE, REQ, DONE, ERR.
- IDLE, `fetch_start`=1: latch `pc` into `mem_addr`, clear wait counter, go to REQ. Otherwise stay. `mem_ack` in IDLE is ignored.
- REQ, `mem_req`=1:
  - `flush`=1 has top priority: go to IDLE; IR unchanged; no pulse. This holds even if `mem_ack`=1 in the same cycle.
  - Else `mem_ack`=1: IR <= `mem_rdata`, go to DONE.
  - Else if counter == timeout_cycles-1: go to ERR.
  - Else: counter + 1.
- DONE: `ir_valid`=1, go to IDLE. ERR: `fetch_err`=1, go to IDLE.
- `fetch_start` outside IDLE is ignored, not queued. `flush` outside REQ has no effect.
- `pc` changes after the accepting edge do not affect `mem_addr`.
- Decode fields are combinational slices of the IR register. They are stable between IR writes and hold the last fetched instruction through flush, error, and idle.
- Counter is 8 bits and cannot wrap, because the timeout caps it.
- Reset (any state, including mid-REQ): state IDLE; `ir`, `mem_addr`, counter = 0; `mem_req`, `busy`, `ir_valid`, `fetch_err` = 0. All decode fields are therefore 0.

## Timing
- `fetch_start` sampled at edge N: `mem_req`=1 and `busy`=1 from cycle N+1.
- Ack sampled at edge M (in REQ): new IR and `ir_valid`=1 in cycle M+1, with `mem_req`=0. `busy`=0 from M+2.
- Minimum latency is start at N, ack at N+1, `ir_valid` at N+2.
- Next `fetch_start` is accepted at edge M+2 at the earliest.
- Timeout: REQ occupies cycles N+1..N+timeout_cycles. An ack in the last of these is still accepted. Without an ack, `fetch_err` is high in cycle N+timeout_cycles+1.
- `mem_req` is registered from state. It drops in the cycle after the ack edge; memory must not present a second ack for the same request.

## Test plan
- Reset then idle: after reset high 2 cycles, all outputs 0; `mem_ack`=1 in IDLE leaves `ir`=0 and `ir_valid`=0.
- Basic fetch: `pc`=0x00400000, start at N, ack at N+3 with 0x3C08ABCD → `mem_addr`=0x00400000, `ir_valid` in N+4, `opcode`=0x0F, `rt`=8, `imm`=0xABCD, `target`=0x008ABCD; `busy` low at N+5.
- R-type decode: ack 0x012A4020 → `rs`=9, `rt`=10, `rd`=8, `shamt`=0, `funct`=0x20.
- Timeout, default 16: start at N, no ack → `fetch_err` single pulse in N+17, IR unchanged. Repeat with ack at N+16 → `ir_valid` in N+17, no error.
- Flush + ack same cycle in REQ → IDLE next cycle, no `ir_valid`, IR holds previous 0x3C08ABCD. `fetch_start` while busy is ignored: `mem_addr` keeps its original value.
- Reset asserted mid-REQ → next cycle `mem_req`=0, `ir`=0. A late ack afterwards is ignored.
